// File: rtl/unified_mem_arbiter.sv
// rtl/unified_mem_arbiter.sv - shares one single-port word memory between fetch (I) and load/store (D) ports
// Optional ROUND_ROBIN_EN: alternate grants under contention; default build is fixed D-over-I priority.
module unified_mem_arbiter #(
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_done,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_done,
  output logic              m_en,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata,
  output logic              busy
);

  localparam int CNT_W = $clog2(MEM_LAT) + 1;

  generate
    if (MEM_LAT < 1 || MEM_LAT > 8) begin : g_bad_mem_lat
      $error("unified_mem_arbiter: MEM_LAT must be within 1..8");
    end
  endgenerate

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              owner_q, owner_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] m_addr_q, m_addr_d;
  logic [DATA_W-1:0] m_wdata_q, m_wdata_d;
  logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              m_en_q, m_en_d;
  logic              m_we_q, m_we_d;
  logic              i_done_q, i_done_d;
  logic              d_done_q, d_done_d;
  logic              busy_q, busy_d;
  logic              grant_d_port;
  logic              capture;
`ifdef ROUND_ROBIN_EN
  logic              last_d_q, last_d_d;
`endif

  // grant_d_port: 1 selects the load/store port, 0 the fetch port
  always_comb begin
`ifdef ROUND_ROBIN_EN
    if (i_req && d_req) grant_d_port = ~last_d_q;
    else                grant_d_port = d_req;
`else
    grant_d_port = d_req;
`endif
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      owner_q   <= 1'b0;
      we_q      <= 1'b0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
      m_en_q    <= 1'b0;
      m_we_q    <= 1'b0;
      i_done_q  <= 1'b0;
      d_done_q  <= 1'b0;
      busy_q    <= 1'b0;
`ifdef ROUND_ROBIN_EN
      last_d_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      owner_q   <= owner_d;
      we_q      <= we_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
      m_en_q    <= m_en_d;
      m_we_q    <= m_we_d;
      i_done_q  <= i_done_d;
      d_done_q  <= d_done_d;
      busy_q    <= busy_d;
`ifdef ROUND_ROBIN_EN
      last_d_q  <= last_d_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE:  if (i_req || d_req) state_d = S_ISSUE;
      S_ISSUE: begin
        state_d = S_WAIT;
        cnt_d   = CNT_W'(MEM_LAT - 1);
      end
      S_WAIT: begin
        if (cnt_q == '0) state_d = S_RESP;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are registered, so they are decoded from the next state
  always_comb begin
    owner_d   = owner_q;
    we_d      = we_q;
    m_addr_d  = m_addr_q;
    m_wdata_d = m_wdata_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
`ifdef ROUND_ROBIN_EN
    last_d_d  = last_d_q;
`endif
    if (state_q == S_IDLE && (i_req || d_req)) begin
      owner_d   = grant_d_port;
      we_d      = grant_d_port & d_we;
      m_addr_d  = grant_d_port ? d_addr : i_addr;
      m_wdata_d = grant_d_port ? d_wdata : '0;
`ifdef ROUND_ROBIN_EN
      last_d_d  = grant_d_port;
`endif
    end
    capture = (state_q == S_WAIT) && (cnt_q == '0) && !we_q;
    if (capture && owner_q)  d_rdata_d = m_rdata;
    if (capture && !owner_q) i_rdata_d = m_rdata;
    m_en_d   = (state_d == S_ISSUE);
    m_we_d   = (state_d == S_ISSUE) && we_d;
    i_done_d = (state_d == S_RESP) && !owner_q;
    d_done_d = (state_d == S_RESP) && owner_q;
    busy_d   = (state_d != S_IDLE);
  end

  assign m_en    = m_en_q;
  assign m_we    = m_we_q;
  assign m_addr  = m_addr_q;
  assign m_wdata = m_wdata_q;
  assign i_rdata = i_rdata_q;
  assign d_rdata = d_rdata_q;
  assign i_done  = i_done_q;
  assign d_done  = d_done_q;
  assign busy    = busy_q;

endmodule
